// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin sharing of one 8N1 UART transmitter between
//                NUM_REQ byte producers, with start/busy/done/gap sequencing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 2048
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_byte,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [2:0]             grant_id,
    output logic                   active,
    output logic                   err_timeout
);

    localparam int CNT_LIM = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = (CNT_LIM < 2) ? 1 : $clog2(CNT_LIM);
    localparam int IDX_W   = $clog2(NUM_REQ);

    localparam logic [CNT_W-1:0] c_busy_last = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]       c_ptr_rst   = 3'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    localparam state_t c_after_xfer = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    state_t             r_state,  w_state_nxt;
    logic [NUM_REQ-1:0] r_ready,  w_ready_nxt;
    logic               r_start,  w_start_nxt;
    logic [7:0]         r_byte,   w_byte_nxt;
    logic [2:0]         r_ptr,    w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic               r_err,    w_err_nxt;
    logic               r_active;
    logic               w_found;
    logic [2:0]         w_winner;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        logic [IDX_W-1:0] idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = 3'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = '0;
        w_start_nxt = 1'b0;
        w_byte_nxt  = r_byte;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_found && !tx_busy) begin
                    w_ready_nxt = NUM_REQ'(1) << w_winner;
                    w_byte_nxt  = req_data[8*w_winner +: 8];
                    w_ptr_nxt   = w_winner;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_start_nxt = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == c_busy_last) begin
                    // Transmitter never answered: drop the byte, flag it, move on.
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_after_xfer;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_after_xfer;
                end
            end
            S_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ready  <= '0;
            r_start  <= 1'b0;
            r_byte   <= '0;
            r_ptr    <= c_ptr_rst;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= w_ready_nxt;
            r_start  <= w_start_nxt;
            r_byte   <= w_byte_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_active <= (w_state_nxt != S_IDLE);
        end
    end

    assign req_ready   = r_ready;
    assign tx_start    = r_start;
    assign tx_byte     = r_byte;
    assign grant_id    = r_ptr;
    assign active      = r_active;
    assign err_timeout = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Scoreboard bench for uart_tx_arbiter with a simple busy model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int GAP_CYCLES   = 16;
    localparam int BUSY_TIMEOUT = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_byte;
    logic                 tx_start;
    logic                 tx_busy;
    logic [2:0]           grant_id;
    logic                 active;
    logic                 err_timeout;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .GAP_CYCLES   (GAP_CYCLES),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_byte     (tx_byte),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ready;
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   grants   = 0;
    int   busy_len = 20;
    bit   model_en = 1'b1;
    int   fall_cyc = 0;
    int   last_grant_cyc = 0;
    bit   spacing_en = 1'b0;
    bit   have_prev  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic push_exp(input int id, input logic [7:0] data);
        exp_t e;
        e.ready = 4'b0001 << id;
        e.id    = 3'(id);
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_grants(input int count, input int budget);
        int target = grants + count;
        int k = 0;
        while (grants < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq("grant_wait", (grants >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (active && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("idle_reached", active, 0);
    endtask

    task automatic reset_dut();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Transmitter model: busy rises right after tx_start, stays up busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && model_en) begin
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy  = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    // Output side of the scoreboard.
    initial begin
        exp_t e;
        bit   pend_start = 1'b0;
        logic [7:0] pend_byte = 8'h00;
        int   prev_cyc = 0;
        forever begin
            @(negedge clk);
            if (pend_start) begin
                check_eq("tx_start_after_grant", tx_start, 1);
                check_eq("tx_byte", tx_byte, pend_byte);
                check_eq("active_in_xfer", active, 1);
                pend_start = 1'b0;
            end
            if (rst_n && req_ready != '0) begin
                grants++;
                last_grant_cyc = cyc;
                check_eq("ready_start_excl", tx_start, 0);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_grant", req_ready, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("grant_onehot", req_ready, e.ready);
                    check_eq("grant_id", grant_id, e.id);
                    pend_byte  = e.data;
                    pend_start = 1'b1;
                end
                if (spacing_en && have_prev) begin
                    check_eq("accept_spacing", ((cyc - prev_cyc) >= 3 + busy_len + GAP_CYCLES) ? 1 : 0, 1);
                    check_eq("gap_after_busy", ((cyc - fall_cyc) >= GAP_CYCLES + 1) ? 1 : 0, 1);
                end
                have_prev = 1'b1;
                prev_cyc  = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  lat;
        int  k;
        bit  bad;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_tx_start", tx_start, 0);
        check_eq("rst_tx_byte", tx_byte, 0);
        check_eq("rst_active", active, 0);
        check_eq("rst_err", err_timeout, 0);
        check_eq("rst_grant_id", grant_id, 3);

        // Single requester, 20-cycle busy.
        busy_len = 20;
        req_data = {8'h00, 8'h00, 8'h00, 8'h52};
        push_exp(0, 8'h52);
        req_valid = 4'b0001;
        wait_grants(1, 20);
        req_valid = '0;
        wait_idle(200);
        check_eq("t1_err", err_timeout, 0);

        // All four held: RR order 0,1,2,3,0 from reset, spacing at the minimum.
        reset_dut();
        busy_len = 5;
        req_data = {8'h33, 8'h32, 8'h31, 8'h30};
        push_exp(0, 8'h30);
        push_exp(1, 8'h31);
        push_exp(2, 8'h32);
        push_exp(3, 8'h33);
        push_exp(0, 8'h30);
        have_prev  = 1'b0;
        spacing_en = 1'b1;
        req_valid  = 4'b1111;
        wait_grants(5, 400);
        req_valid  = '0;
        spacing_en = 1'b0;
        wait_idle(200);

        // Move pointer to 2, then 0011 must wrap to 0, then alternate.
        push_exp(2, 8'h32);
        req_valid = 4'b0100;
        wait_grants(1, 20);
        req_valid = '0;
        wait_idle(200);
        push_exp(0, 8'h30);
        push_exp(1, 8'h31);
        push_exp(0, 8'h30);
        req_valid = 4'b0011;
        wait_grants(3, 300);
        req_valid = '0;
        wait_idle(200);

        // Transmitter never goes busy: timeout, sticky error, next request still served.
        model_en = 1'b0;
        req_data = {8'h33, 8'h32, 8'h6B, 8'hA5};
        push_exp(0, 8'hA5);
        req_valid = 4'b0001;
        wait_grants(1, 20);
        req_valid = '0;
        @(negedge clk);
        lat = 0;
        while (!err_timeout && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("timeout_latency", (lat >= BUSY_TIMEOUT - 1 && lat <= BUSY_TIMEOUT) ? 1 : 0, 1);
        wait_idle(200);
        check_eq("err_sticky_idle", err_timeout, 1);
        model_en = 1'b1;
        busy_len = 5;
        push_exp(1, 8'h6B);
        req_valid = 4'b0010;
        wait_grants(1, 20);
        req_valid = '0;
        wait_idle(200);
        check_eq("err_sticky_after", err_timeout, 1);

        // Reset asserted during WAIT_DONE.
        busy_len = 30;
        req_data = {8'h33, 8'h77, 8'h11, 8'h10};
        push_exp(2, 8'h77);
        req_valid = 4'b0100;
        wait_grants(1, 20);
        req_valid = '0;
        k = 0;
        while (!tx_busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_req_ready", req_ready, 0);
        check_eq("arst_tx_start", tx_start, 0);
        check_eq("arst_tx_byte", tx_byte, 0);
        check_eq("arst_active", active, 0);
        check_eq("arst_err", err_timeout, 0);
        check_eq("arst_grant_id", grant_id, 3);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Transmitter is still busy from the abandoned byte: no grant until it drops.
        push_exp(0, 8'h10);
        req_valid = 4'b0011;
        bad = 1'b0;
        k = 0;
        while (tx_busy && k < 100) begin
            @(negedge clk); #1;
            if (req_ready != '0) bad = 1'b1;
            k++;
        end
        check_eq("no_grant_while_busy", bad, 0);
        wait_grants(1, 20);
        req_valid = '0;
        check_eq("grant_after_busy_fall", (last_grant_cyc > fall_cyc) ? 1 : 0, 1);
        wait_idle(200);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
